// File: rtl/mm_share_arbiter_pkg.sv
// Shared definitions for the two-requester Montgomery multiplier arbiter.
package mm_share_arbiter_pkg;

    localparam int MM_K_DEF = 128;
    localparam int MM_N_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_DONE
    } mm_state_t;

endpackage

// File: rtl/mm_share_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the favoured requester on a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_adv,
    output logic [1:0] o_gnt
);

    logic r_ptr;

    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= 1'b0;
        else if (i_adv)
            r_ptr <= ~r_ptr;
    end

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mm_share_arbiter.sv
// Shares one Montgomery multiplier between two requesters: load N operand
// words from the winner, launch the task, forward result words back.
module mm_share_arbiter
    import mm_share_arbiter_pkg::*;
#(
    parameter int K = MM_K_DEF,
    parameter int N = MM_N_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req,
    output logic [1:0]           grant,
    input  logic [1:0]           wr_valid,
    input  logic [K-1:0]         wr_x0,
    input  logic [K-1:0]         wr_y0,
    input  logic [K-1:0]         wr_m0,
    input  logic [K-1:0]         wr_x1,
    input  logic [K-1:0]         wr_y1,
    input  logic [K-1:0]         wr_m1,
    output logic [1:0]           res_valid,
    output logic [K-1:0]         res_data,
    output logic [1:0]           done,
    output logic                 err,
    output logic [2:0]           mm_wr_ena,
    output logic [$clog2(N)-1:0] mm_wr_addr,
    output logic [K-1:0]         mm_wr_x,
    output logic [K-1:0]         mm_wr_y,
    output logic [K-1:0]         mm_wr_m,
    output logic                 mm_task_req,
    input  logic                 mm_task_end,
    input  logic                 mm_task_grant,
    input  logic [K-1:0]         mm_task_res
);

    localparam int AW = $clog2(N);
    localparam int CW = AW + 1;

    mm_state_t     r_state, w_next;
    logic [1:0]    r_grant;
    logic [1:0]    w_arb_gnt;
    logic [AW-1:0] r_wcnt;
    logic [CW-1:0] r_rcnt;
    logic [1:0]    r_res_valid;
    logic [K-1:0]  r_res_data;
    logic [2:0]    r_wr_ena;
    logic [AW-1:0] r_wr_addr;
    logic [K-1:0]  r_wr_x, r_wr_y, r_wr_m;
    logic          w_accept;
    logic          w_last;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (req),
        .i_adv (r_state == ST_DONE),
        .o_gnt (w_arb_gnt)
    );

    assign w_accept = (r_state == ST_LOAD) && |(wr_valid & r_grant);
    assign w_last   = w_accept && (r_wcnt == AW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (|req) w_next = ST_LOAD;
            ST_LOAD:  if (w_last) w_next = ST_START;
            ST_START: w_next = ST_RUN;
            ST_RUN:   if (mm_task_end) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant     <= '0;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_res_valid <= '0;
            r_res_data  <= '0;
            r_wr_ena    <= '0;
            r_wr_addr   <= '0;
            r_wr_x      <= '0;
            r_wr_y      <= '0;
            r_wr_m      <= '0;
        end else begin
            r_wr_ena    <= '0;
            r_res_valid <= '0;
            if (r_state == ST_IDLE && |req)
                r_grant <= w_arb_gnt;
            // Word count wraps to 0 after N-1 because N is a power of two.
            if (w_accept) begin
                r_wr_ena  <= 3'b111;
                r_wr_addr <= r_wcnt;
                r_wr_x    <= r_grant[1] ? wr_x1 : wr_x0;
                r_wr_y    <= r_grant[1] ? wr_y1 : wr_y0;
                r_wr_m    <= r_grant[1] ? wr_m1 : wr_m0;
                r_wcnt    <= r_wcnt + 1'b1;
            end
            if (r_state == ST_RUN && mm_task_grant) begin
                r_res_valid <= r_grant;
                r_res_data  <= mm_task_res;
                if (r_rcnt != '1)
                    r_rcnt <= r_rcnt + 1'b1;
            end
            if (r_state == ST_DONE) begin
                r_grant <= '0;
                r_wcnt  <= '0;
                r_rcnt  <= '0;
            end
        end
    end

    assign grant       = r_grant;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign mm_wr_ena   = r_wr_ena;
    assign mm_wr_addr  = r_wr_addr;
    assign mm_wr_x     = r_wr_x;
    assign mm_wr_y     = r_wr_y;
    assign mm_wr_m     = r_wr_m;
    assign mm_task_req = (r_state == ST_START);
    assign done        = (r_state == ST_DONE) ? r_grant : 2'b00;
    assign err         = (r_state == ST_DONE) && (r_rcnt != CW'(N));

endmodule

// File: doc/mm_share_arbiter.md
MM_SHARE_ARBITER -- requirements
Module: mm_share_arbiter

Interface
REQ-001 The block SHALL have parameter K, default 128, giving the bits per word.
REQ-002 The block SHALL have parameter N, default 32, giving the words per operand; N is a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port req, input, 2 bits: requester i wants one modular multiplication.
REQ-006 The block SHALL have port grant, output, 2 bits: one-hot-or-zero; requester i owns the multiplier.
REQ-007 The block SHALL have port wr_valid, input, 2 bits: operand word from requester i is valid this cycle.
REQ-008 The block SHALL have ports wr_x0, wr_y0, wr_m0, wr_x1, wr_y1, wr_m1, input, K bits each: operand words, low word first.
REQ-009 The block SHALL have port res_valid, output, 2 bits: a result word for requester i is valid.
REQ-010 The block SHALL have port res_data, output, K bits: the result word, low word first.
REQ-011 The block SHALL have port done, output, 2 bits: one-cycle pulse when requester i's task completes.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle pulse when the result word count differs from N at task end.
REQ-013 The block SHALL have ports mm_wr_ena (3 bits), mm_wr_addr (clog2(N) bits), mm_wr_x, mm_wr_y and mm_wr_m (K bits each), all outputs, driving the Montgomery multiplier write port.
REQ-014 The block SHALL have ports mm_task_req, output, 1 bit, and mm_task_end, mm_task_grant (1 bit) and mm_task_res (K bits), inputs, connecting to the multiplier task port.

Function
REQ-015 The block SHALL implement the states IDLE, LOAD, START, RUN and DONE.
REQ-016 In IDLE with req nonzero, the block SHALL register grant to the winner and enter LOAD; with no request it SHALL stay in IDLE.
REQ-017 When exactly one requester asserts req, that requester SHALL win.
REQ-018 When both requesters assert req, the requester selected by the round-robin pointer SHALL win; the pointer resets to 0 and flips to the other requester at each DONE.
REQ-019 In LOAD, each cycle with wr_valid[g] high (g = granted requester) SHALL produce, on the next cycle, mm_wr_ena=3'b111, mm_wr_addr=word count, and mm_wr_x/y/m equal to requester g's word; the word count then increments.
REQ-020 Gaps in wr_valid during LOAD SHALL be allowed, with mm_wr_ena=0 on those cycles.
REQ-021 wr_valid from the non-granted requester SHALL be ignored.
REQ-022 After word N-1 is accepted the block SHALL enter START; word N-1 SHALL be written on the same cycle START is active, and further wr_valid SHALL be ignored.
REQ-023 START SHALL assert mm_task_req for exactly one cycle and then enter RUN.
REQ-024 In RUN, each mm_task_grant SHALL be registered to res_valid[g] with res_data=mm_task_res one cycle later, and SHALL increment a result counter.
REQ-025 mm_task_end SHALL move RUN to DONE.
REQ-026 If mm_task_grant and mm_task_end arrive in the same cycle, the result word SHALL still be forwarded and counted.
REQ-027 DONE SHALL pulse done[g], drop grant, update the pointer, pulse err if the result count is not N, clear the counters, and return to IDLE, all in one cycle.
REQ-028 Deasserting req after grant SHALL not abort the transaction; the task SHALL always run to DONE.
REQ-029 A requester SHALL be able to win again on the cycle after DONE if the other requester is not requesting.
REQ-030 mm_task_end arriving outside RUN SHALL be ignored.

Reset
REQ-031 When rst is high at a clock edge, the block SHALL go to IDLE and clear the pointer and counters.
REQ-032 Under reset, grant, res_valid, done, err, mm_wr_ena and mm_task_req SHALL be 0, and mm_wr_addr, mm_wr_x/y/m and res_data SHALL be 0.
REQ-033 A reset asserted mid-operation SHALL abandon the task with no done pulse.

Structure
REQ-034 A shared package SHALL hold the state enum and the default K and N values.
REQ-035 The block SHALL contain one sub-module, rr_arb2: a two-input round-robin arbiter holding the pointer.
REQ-036 The Montgomery multiplier SHALL be instantiated outside this block.

Verification (N=4, K=8)
REQ-037 req=01, words x=1..4, y=5..8, m=9..12 -> mm_wr_addr 0..3 with those words, mm_task_req one pulse, 4 mm_task_grant -> res_valid[0] x4, done[0], err=0.
REQ-038 req=11 from reset -> grant=01 first; after done[0], grant=10; next simultaneous request -> grant=01.
REQ-039 wr_valid pattern 1,0,0,1,1,0,1 -> mm_wr_addr 0,1,2,3 only on valid cycles; wr_valid[1] pulses during grant=01 cause no writes.
REQ-040 mm_task_end after 3 grants -> done pulse with err=1; mm_task_grant and mm_task_end in the same cycle -> word forwarded.
REQ-041 rst asserted during LOAD at word 2 -> next cycle all outputs 0 and IDLE; next request restarts at mm_wr_addr 0.
REQ-042 req dropped during RUN -> results still delivered and done pulses.
